// File: rtl/result_link_rx.sv
// ============================================================================
// Module   : result_link_rx
// Brief    : Oversampled SPI receiver for the DSP PIC result byte; holds a
//            checked 3-bit code for the display stage and shifts back an ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_link_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs_n,
    input  logic       clear,
    output logic       sdo,
    output logic [2:0] result,
    output logic       result_valid,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam logic [2:0] c_HEADER    = 3'b101;
    localparam logic [2:0] c_RES_NONE  = 3'b111;
    localparam logic [2:0] c_CODE_MAX  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SHIFT      = 2'd1,
        S_CHECK      = 2'd2,
        S_WAIT_DESEL = 2'd3
    } state_t;

    // Two-flop synchronizers plus one extra sck stage for edge detection
    logic sck_meta_q, s_sck_q, sck_dly_q;
    logic sdi_meta_q, s_sdi_q;
    logic cs_meta_q,  s_cs_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_meta_q <= 1'b0;
            s_sck_q    <= 1'b0;
            sck_dly_q  <= 1'b0;
            sdi_meta_q <= 1'b0;
            s_sdi_q    <= 1'b0;
            cs_meta_q  <= 1'b1;
            s_cs_n_q   <= 1'b1;
        end else begin
            sck_meta_q <= sck;
            s_sck_q    <= sck_meta_q;
            sck_dly_q  <= s_sck_q;
            sdi_meta_q <= sdi;
            s_sdi_q    <= sdi_meta_q;
            cs_meta_q  <= cs_n;
            s_cs_n_q   <= cs_meta_q;
        end
    end

    logic w_sck_rise, w_sck_fall;
    assign w_sck_rise =  s_sck_q & ~sck_dly_q;
    assign w_sck_fall = ~s_sck_q &  sck_dly_q;

    state_t     state_q;
    logic [7:0] shift_q;
    logic [2:0] cnt_q;
    logic [7:0] ack_q;
    logic       sdo_q;
    logic [2:0] result_q;
    logic       result_valid_q;
    logic       frame_err_q;
    logic [7:0] err_count_q;

    logic [2:0] w_header, w_code;
    logic       w_accept;
    logic [1:0] w_unused_rsvd;
    assign w_header      = shift_q[7:5];
    assign w_code        = shift_q[2:0];
    assign w_unused_rsvd = shift_q[4:3];
    assign w_accept      = (w_header == c_HEADER) && (w_code <= c_CODE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            shift_q        <= 8'h00;
            cnt_q          <= 3'd0;
            ack_q          <= 8'h00;
            sdo_q          <= 1'b0;
            result_q       <= c_RES_NONE;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            err_count_q    <= 8'h00;
        end else begin
            frame_err_q <= 1'b0;
            if (clear) begin
                result_q       <= c_RES_NONE;
                result_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    sdo_q <= 1'b0;
                    if (!s_cs_n_q) begin
                        state_q <= S_SHIFT;
                        cnt_q   <= 3'd0;
                        // Header MSB goes straight to sdo; ack_q holds bits 6..0
                        sdo_q   <= c_HEADER[2];
                        ack_q   <= {c_HEADER[1:0], 2'b00, result_q, 1'b0};
                    end
                end

                S_SHIFT: begin
                    if (s_cs_n_q) begin
                        state_q     <= S_IDLE;
                        sdo_q       <= 1'b0;
                        frame_err_q <= 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end else begin
                        if (w_sck_rise) begin
                            shift_q <= {shift_q[6:0], s_sdi_q};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                state_q <= S_CHECK;
                            end
                        end
                        if (w_sck_fall) begin
                            sdo_q <= ack_q[7];
                            ack_q <= {ack_q[6:0], 1'b0};
                        end
                    end
                end

                S_CHECK: begin
                    state_q <= S_WAIT_DESEL;
                    if (w_accept) begin
                        // A coincident clear discards the frame silently
                        if (!clear) begin
                            result_q       <= w_code;
                            result_valid_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                end

                S_WAIT_DESEL: begin
                    if (s_cs_n_q) begin
                        state_q <= S_IDLE;
                        sdo_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    sdo_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sdo          = sdo_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;
    assign err_count    = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_result_link_rx.sv
// ============================================================================
// Module   : tb_result_link_rx
// Brief    : Scoreboard bench for result_link_rx with directed SPI frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_link_rx;

    logic       clk = 1'b0;
    logic       reset, sck, sdi, cs_n, clear;
    logic       sdo;
    logic [2:0] result;
    logic       result_valid;
    logic       frame_err;
    logic [7:0] err_count;

    result_link_rx dut (
        .clk          (clk),
        .reset        (reset),
        .sck          (sck),
        .sdi          (sdi),
        .cs_n         (cs_n),
        .clear        (clear),
        .sdo          (sdo),
        .result       (result),
        .result_valid (result_valid),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [2:0] res;
        logic       vld;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    logic [2:0] m_res = 3'b111;
    logic       m_vld = 1'b0;
    logic [7:0] m_cnt = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every frame_err pulse or change of {result,result_valid} pops one event
    logic [3:0] prev_out = 4'b1110;
    logic       prev_err = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            prev_out = {result, result_valid};
            prev_err = 1'b0;
        end else begin
            if (frame_err) begin
                checks++;
                if (prev_err) begin
                    failures++;
                    $display("FAIL frame_err_width actual=2+ cycles expected=1 cycle");
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL err_event actual=frame_err expected=no event");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_err) begin
                        failures++;
                        $display("FAIL err_event actual=frame_err expected=result %b valid %b", e.res, e.vld);
                    end
                end
            end
            if ({result, result_valid} !== prev_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL res_event actual=%b/%b expected=no change", result, result_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err || {e.res, e.vld} !== {result, result_valid}) begin
                        failures++;
                        $display("FAIL res_event actual=%b/%b expected=%b/%b err=%b",
                                 result, result_valid, e.res, e.vld, e.is_err);
                    end
                end
            end
            prev_out = {result, result_valid};
            prev_err = frame_err;
        end
    end

    task automatic push_err();
        exp_q.push_back('{is_err: 1'b1, res: 3'b000, vld: 1'b0});
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic push_res(input logic [2:0] r, input logic v);
        if ({r, v} != {m_res, m_vld})
            exp_q.push_back('{is_err: 1'b0, res: r, vld: v});
        m_res = r;
        m_vld = v;
    endtask

    // mode 0: plain, 1: check latency at the 8th rise, 2: clear in the CHECK cycle
    task automatic frame(input logic [15:0] data, input int nbits, input int mode);
        logic [7:0] byte_v, ack_exp, got;
        logic [2:0] pre_res;
        logic       pre_vld, accept;
        pre_res = m_res;
        pre_vld = m_vld;
        ack_exp = {3'b101, 2'b00, m_res};
        got     = 8'h00;
        if (nbits < 8) begin
            push_err();
        end else begin
            byte_v = data[nbits-1 -: 8];
            accept = (byte_v[7:5] == 3'b101) && (byte_v[2:0] <= 3'b100);
            if (!accept) push_err();
            if (mode == 2)   push_res(3'b111, 1'b0);
            else if (accept) push_res(byte_v[2:0], 1'b1);
        end

        @(negedge clk) cs_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdi = data[nbits-1-i];
            repeat (5) @(negedge clk);
            if (i < 8) got[7-i] = sdo;
            sck = 1'b1;
            if (i == 7 && mode != 0) begin
                repeat (3) @(posedge clk);
                #1;
                if (mode == 1) chk("latency_pre", {pre_res, pre_vld}, {m_res == pre_res ? pre_res : pre_res, pre_vld});
                if (mode == 2) clear = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
                if (mode == 1) chk("latency_post", {result, result_valid}, {m_res, m_vld});
                repeat (2) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            sck = 1'b0;
        end
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        if (nbits >= 8) chk("ack_byte", got, ack_exp);
    endtask

    initial begin
        reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 3'b111);
        chk("reset_valid", result_valid, 1'b0);
        chk("reset_err_count", err_count, 8'h00);
        chk("reset_sdo", sdo, 1'b0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);

        frame(16'h00A3, 8, 1);                 // 101_00_011
        frame(16'h00C2, 8, 0);                 // bad header
        frame(16'h00A6, 8, 0);                 // bad code 110
        chk("err_count_2", err_count, 8'd2);
        chk("result_held", {result, result_valid}, 4'b0111);

        frame(16'h0014, 5, 0);                 // short frame 10100
        chk("idle_sdo_after_abort", sdo, 1'b0);
        frame(16'h00A1, 8, 1);                 // 101_00_001
        frame(16'h00A4, 8, 2);                 // clear collides with CHECK
        frame(16'h0A2F, 12, 0);                // 101_00_010 plus 4 extra edges
        chk("err_count_3", err_count, m_cnt);

        push_res(3'b111, 1'b0);
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        repeat (4) @(negedge clk);

        for (int n = 0; n < 260; n++) frame(16'h0000, 8, 0);
        chk("err_count_sat", err_count, 8'hFF);
        chk("err_count_model", err_count, m_cnt);

        repeat (20) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_link_rx.md
# result_link_rx

Receives the speech-processing result from the DSP PIC over a dedicated 3-wire SPI link and holds it as a stable 3-bit code for the peripherals display stage. The stage is directly upstream of the peripherals module and drives its `result[2:0]` input. SPI pins are oversampled in the system clock domain, so the block has a single clock. Frames are header-checked and range-checked, then latched. An acknowledge byte is shifted back to the PIC so it can confirm delivery.

## Interface
- No parameters. Frame length is fixed at 8 bits and the header is fixed at 3'b101.
- clk  input  1  system clock; all logic runs on posedge clk
- reset  input  1  synchronous, active-high reset
- sck  input  1  SPI clock from DSP PIC, mode 0, asynchronous to clk
- sdi  input  1  SPI data from PIC, MSB first
- cs_n  input  1  SPI chip select, active low
- clear  input  1  one-cycle pulse from system control when a new recording starts
- sdo  output  1  SPI data to PIC (acknowledge byte)
- result  output  3  held result: 001 R, 010 G, 011 Y, 100 O, 000 fail, 111 none
- result_valid  output  1  high while `result` holds a frame-delivered value
- frame_err  output  1  one-cycle pulse per rejected frame
- err_count  output  8  saturating count of rejected frames

## Operation
- **Synchronizers:** each of sck, sdi and cs_n passes through a 2-flop synchronizer. Reset values are sck 0, sdi 0, cs_n 1.
  - The rising sck edge is `s_sck & ~s_sck_d`.
  - The falling sck edge is `~s_sck & s_sck_d`.
  - sdi is taken from the same sync stage as sck.
- **Frame format, MSB first:** [7:5] header, must be 3'b101; [4:3] reserved, ignored; [2:0] result code.
- **State machine:** states are IDLE, SHIFT, CHECK and WAIT_DESEL. Reset enters IDLE.
  - IDLE: on synced cs_n low, go to SHIFT. Clear the bit counter to 0 and load the ack register.
  - SHIFT: on each rising sck edge, shift s_sdi into the LSB of an 8-bit shift register and increment the 3-bit counter.
    - After the 8th rising edge (counter wraps 7→0), go to CHECK.
    - If cs_n goes high before the 8th edge, go to IDLE, pulse frame_err, and leave the latched result unchanged.
  - CHECK: lasts exactly one cycle.
    - Accept the frame if header == 3'b101 and code ∈ {000, 001, 010, 011, 100}. On accept, latch result and set result_valid = 1.
    - Otherwise pulse frame_err. Codes 101, 110 and 111 are rejected.
    - Always go to WAIT_DESEL.
  - WAIT_DESEL: ignore all sck edges. Go to IDLE when cs_n is high.
- **Acknowledge path:**
  - The ack byte is {3'b101, 2'b00, result as held at frame start}.
  - Bit 7 is presented on sdo from entry into SHIFT. The next bit is presented on each falling sck edge.
  - sdo = 0 whenever the state is IDLE.
- **clear:** forces result = 3'b111 and result_valid = 0 on the next clk edge.
  - clear in the same cycle as an accepting CHECK: clear wins, the frame is discarded, and frame_err is not pulsed.
  - clear does not alter FSM state or err_count.
- **err_count:** increments on every frame_err pulse and saturates at 8'hFF. Only reset clears it.
- **Reset values:**
  - FSM state IDLE.
  - result 3'b111, result_valid 0, frame_err 0, err_count 0, sdo 0.
  - Shift register and counter 0.
  - Reset mid-frame aborts the frame without a frame_err pulse.

## Timing
- sck high and low phases must each be ≥ 4 clk periods. cs_n setup to the first sck rise must be ≥ 4 clk periods. Behaviour for faster sck is undefined.
- Latency from the 8th sck rising edge at the pin:
  - synchronized by edge 2;
  - shift and CHECK entry at edge 3;
  - result, result_valid and frame_err update at edge 4.
- result is stable between accepted frames and clears. It never glitches during shifting.
- frame_err is exactly 1 clk wide.
- sdo changes within 3 clk cycles of a falling sck edge at the pin, well inside the sck half-period.

## Test plan
- **Reset:** reset 1 for 3 cycles → result 111, result_valid 0, err_count 0, sdo 0.
- **Valid frame:** send 8'b101_00_011 with sck = clk/10 → result 011 and result_valid 1 at the 4th clk after the 8th sck rise. On the next frame, sdo returns 8'b10100011.
- **Bad header / bad code:** send 8'b110_00_010, then 8'b101_00_110 → two frame_err pulses, err_count 2, result unchanged.
- **Short frame:** raise cs_n after 5 bits → frame_err pulse, FSM in IDLE. A following valid 8'b101_00_001 yields result 001.
- **clear collision:** clear asserted in the CHECK cycle of valid frame 8'b101_00_100 → result 111, result_valid 0, no frame_err.
- **Saturation and extra edges:** send 260 bad frames → err_count holds 8'hFF. Send 12 sck edges in one cs_n window with a valid first byte → only the first 8 bits are used, no error.
